// File: rtl/multiplier_taint_pkg.sv
// Shared types and helpers for the radix multiplier with taint tracking.
// Holds the controller state encoding and the upward taint-spread helper.
package multiplier_taint_pkg;

   // Controller states: IDLE waits for start, LOAD captures operands,
   // RUN retires one multiplier digit per cycle, DONE pulses completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } mult_state_e;

   // Widest taint vector the spread helper handles; callers zero-extend
   // into this width and truncate the result back to their own width.
   localparam int TAINT_W_MAX = 256;

   // Sets the lowest set bit and every bit above it. v | -v works because
   // two's-complement negation keeps the lowest set bit and inverts all
   // higher bits, so the OR fills everything from that bit upward.
   function automatic logic [TAINT_W_MAX-1:0] taint_spread_up(
      input logic [TAINT_W_MAX-1:0] v
   );
      return v | (-v);
   endfunction

endpackage

// File: rtl/multiplier_radix_control_taint_track.sv
// Controller for the radix multiplier: FSM, digit counter and control taint.
// Optional build macro: STATE_TAINT_KILL_EN (lets state_t_kill clear the
// control taint while idle; without it the control taint is sticky).
//
// Handshake: start is a single-cycle request sampled only in IDLE; any start
// seen in LOAD, RUN or DONE is dropped (no queueing). product_done is a
// one-cycle pulse in DONE; busy is high from LOAD through DONE.
module multiplier_radix_control_taint_track
   import multiplier_taint_pkg::*;
#(
   parameter int N  = 16,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          start_t,
   input  logic          state_t_kill,
   output mult_state_e   state,
   output logic [CW-1:0] count,
   output logic          busy,
   output logic          busy_t,
   output logic          product_done,
   output logic          product_done_t
);

   logic ctrl_t;

   // FSM, digit counter, registered busy/done and the control taint register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         busy         <= 1'b0;
         product_done <= 1'b0;
         ctrl_t       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               product_done <= 1'b0;
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
`ifdef STATE_TAINT_KILL_EN
                  ctrl_t <= start_t;
`else
                  ctrl_t <= ctrl_t | start_t;
`endif
               end else begin
`ifdef STATE_TAINT_KILL_EN
                  if (state_t_kill) begin
                     ctrl_t <= 1'b0;
                  end
`else
                  // Kill has no effect in this build: the term is absorbed
                  // by ctrl_t, so the taint stays sticky until reset.
                  ctrl_t <= ctrl_t | (state_t_kill & ctrl_t);
`endif
               end
            end
            LOAD: begin
               state <= RUN;
               count <= '0;
            end
            RUN: begin
               if (count == CW'(N - 1)) begin
                  state        <= DONE;
                  count        <= '0;
                  product_done <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               state        <= IDLE;
               busy         <= 1'b0;
               product_done <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status taints: follow the control taint while the status is asserted,
   // and report it directly while idle.
   always_comb begin
      busy_t         = (busy & ctrl_t) | ((state == IDLE) & ctrl_t);
      product_done_t = (product_done & ctrl_t) | ((state == IDLE) & ctrl_t);
   end

endmodule

// File: rtl/multiplier_radix_taint_track.sv
// Constant-time unsigned radix-2^DIGIT multiplier with bitwise taint
// tracking of operands into the product. The datapath lives here; sequencing
// and control taint live in multiplier_radix_control_taint_track.
// Optional build macro: STATE_TAINT_KILL_EN (see the controller).
module multiplier_radix_taint_track
   import multiplier_taint_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 start_t,
   input  logic                 state_t_kill,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplier_t,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplicand_t,
   output logic [2*WIDTH-1:0]   product,
   output logic [2*WIDTH-1:0]   product_t,
   output logic                 busy,
   output logic                 busy_t,
   output logic                 product_done,
   output logic                 product_done_t
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // One spare bit above the product so the running sum can never wrap.
   localparam int SW = 2 * WIDTH + 1;

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("WIDTH must be a multiple of DIGIT");
      end
      if (SW > TAINT_W_MAX) begin : g_bad_width
         $error("2*WIDTH+1 exceeds TAINT_W_MAX");
      end
   endgenerate

   mult_state_e      state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] mplier_t;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mcand_t;
   logic [SW-1:0]    sum;
   logic [SW-1:0]    sum_t;
   logic [SW-1:0]    add_term;
   logic [SW-1:0]    step_t;
   int               shift;

   multiplier_radix_control_taint_track #(
      .N  (N),
      .CW (CW)
   ) u_ctrl (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .start_t        (start_t),
      .state_t_kill   (state_t_kill),
      .state          (state),
      .count          (count),
      .busy           (busy),
      .busy_t         (busy_t),
      .product_done   (product_done),
      .product_done_t (product_done_t)
   );

   // Partial product for the current digit and its conservative taint. The
   // taint ignores operand values so it cannot leak data through timing or
   // shape: a tainted digit taints everything from its weight upward, and
   // otherwise the shifted multiplicand taint is spread upward for carries.
   always_comb begin
      shift    = int'(count) * DIGIT;
      add_term = ({{(SW - WIDTH){1'b0}}, mcand} *
                  {{(SW - DIGIT){1'b0}}, mplier[DIGIT-1:0]}) << shift;
      if (|mplier_t[DIGIT-1:0]) begin
         step_t = SW'(taint_spread_up(TAINT_W_MAX'({{(SW - 1){1'b0}}, 1'b1} << shift)));
      end else begin
         step_t = SW'(taint_spread_up(TAINT_W_MAX'({{(SW - WIDTH){1'b0}}, mcand_t} << shift)));
      end
   end

   // Operand capture in LOAD, one digit accumulated per RUN cycle; the add
   // happens even for a zero digit so every operation takes the same time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mplier   <= '0;
         mplier_t <= '0;
         mcand    <= '0;
         mcand_t  <= '0;
         sum      <= '0;
         sum_t    <= '0;
      end else if (state == LOAD) begin
         mplier   <= multiplier;
         mplier_t <= multiplier_t;
         mcand    <= multiplicand;
         mcand_t  <= multiplicand_t;
         sum      <= '0;
         sum_t    <= '0;
      end else if (state == RUN) begin
         sum      <= sum + add_term;
         sum_t    <= sum_t | step_t;
         mplier   <= mplier >> DIGIT;
         mplier_t <= mplier_t >> DIGIT;
      end
   end

   // The sum is untouched outside LOAD/RUN, so the result holds until the
   // next LOAD clears it.
   always_comb begin
      product   = sum[2*WIDTH-1:0];
      product_t = sum_t[2*WIDTH-1:0];
   end

endmodule
